// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin arbiter that drives the datapath bus. In IDLE it picks one
//   requesting source. For exactly one cycle it then registers that source's
//   word onto BusMuxOut and asserts a one-hot destination write enable. The
//   destination register captures the word on the edge that ends that cycle.
//
// Optional feature: define BUS_ARB_PRIORITY_EN to give source 0 fixed top
//   priority. Source 0 wins whenever it requests, and those wins leave the
//   round-robin pointer untouched. Sources 1..NUM_SRC-1 round-robin among
//   themselves. With the macro undefined, all sources share one round-robin.
//
// Ports
//   clock      : single clock, rising edge
//   clear      : synchronous active-low reset
//   req        : per-source transfer request            [NUM_SRC]
//   src_data   : source i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_dst    : source i destination id at [i*DST_W +: DST_W]
//   BusMuxOut  : registered bus word                    [DATA_WIDTH]
//   dst_enable : registered one-hot destination enable  [NUM_DST]
//   grant      : registered one-hot grant               [NUM_SRC]
//   bus_valid  : high during the drive cycle
//   dst_err    : high during a drive cycle whose destination id >= NUM_DST
module bus_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 8,
  parameter int NUM_DST    = 16,
  parameter int DST_W      = 4
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic [NUM_SRC-1:0]            req,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC*DST_W-1:0]      src_dst,
  output logic [DATA_WIDTH-1:0]         BusMuxOut,
  output logic [NUM_DST-1:0]            dst_enable,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          bus_valid,
  output logic                          dst_err
);

  localparam int SRC_W = $clog2(NUM_SRC);

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

  state_t               state_p0, state_nxt;
  logic [SRC_W-1:0]     last_p0, last_nxt;
  logic [DATA_WIDTH-1:0] bus_nxt;
  logic [NUM_DST-1:0]   en_nxt;
  logic [NUM_SRC-1:0]   grant_nxt;
  logic                 valid_nxt;
  logic                 err_nxt;

  logic [NUM_SRC-1:0]   rr_req;
  logic [SRC_W:0]       pick;
  logic [SRC_W-1:0]     win;
  logic [DST_W-1:0]     win_dst;
  logic [NUM_DST:0]     dec;

  // Returns {found, index}. The search starts at lst+1 and wraps, so the
  // most recent winner is the last candidate considered.
  function automatic logic [SRC_W:0] rr_pick(input logic [NUM_SRC-1:0] r,
                                             input logic [SRC_W-1:0]   lst);
    logic             found;
    logic [SRC_W-1:0] idx;
    int               cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = (int'(lst) + k) % NUM_SRC;
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = SRC_W'(cand);
      end
    end
    return {found, idx};
  endfunction

  // Returns {err, one-hot}. An id outside the register file yields no enable.
  function automatic logic [NUM_DST:0] dst_decode(input logic [DST_W-1:0] d);
    logic [NUM_DST-1:0] oh;
    oh = '0;
    for (int j = 0; j < NUM_DST; j++) oh[j] = (int'(d) == j);
    return {(int'(d) >= NUM_DST), oh};
  endfunction

`ifdef BUS_ARB_PRIORITY_EN
  // Source 0 is handled by the fixed-priority check, so it is kept out of
  // the rotating search.
  assign rr_req = req & ~NUM_SRC'(1);
`else
  assign rr_req = req;
`endif

  assign pick = rr_pick(rr_req, last_p0);

  always_comb begin
    state_nxt = state_p0;
    last_nxt  = last_p0;
    bus_nxt   = '0;
    en_nxt    = '0;
    grant_nxt = '0;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    win       = pick[SRC_W-1:0];
    win_dst   = '0;
    dec       = '0;
    case (state_p0)
      IDLE: begin
        if (|req) begin
`ifdef BUS_ARB_PRIORITY_EN
          if (req[0]) win = '0;
          else        last_nxt = win;
`else
          last_nxt = win;
`endif
          win_dst   = src_dst[int'(win)*DST_W +: DST_W];
          dec       = dst_decode(win_dst);
          bus_nxt   = src_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          en_nxt    = dec[NUM_DST-1:0];
          err_nxt   = dec[NUM_DST];
          grant_nxt[win] = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: state, round-robin pointer and every registered output
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_p0   <= IDLE;
      last_p0    <= SRC_W'(NUM_SRC - 1);
      BusMuxOut  <= '0;
      dst_enable <= '0;
      grant      <= '0;
      bus_valid  <= 1'b0;
      dst_err    <= 1'b0;
    end else begin
      state_p0   <= state_nxt;
      last_p0    <= last_nxt;
      BusMuxOut  <= bus_nxt;
      dst_enable <= en_nxt;
      grant      <= grant_nxt;
      bus_valid  <= valid_nxt;
      dst_err    <= err_nxt;
    end
  end

endmodule
